// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller: multicycle RISC-V main control FSM with retired-instruction counter.
// Optional ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP until reset.
module riscv_multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       opcode,
    input  logic             Zero,
    output logic [1:0]       ALUOP,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstRet
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWRITE = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP     = 4'd11;
    localparam logic [3:0] S_ILLEGAL  = S_TRAP;
`else
    localparam logic [3:0] S_ILLEGAL  = S_FETCH;
`endif
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] inst_ret_q, inst_ret_d;
    logic             retire;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                                 (opcode == OP_R)   ? S_EXECR :
                                 (opcode == OP_I)   ? S_EXECI :
                                 (opcode == OP_BEQ) ? S_BEQ   :
                                 (opcode == OP_JAL) ? S_JAL   : S_ILLEGAL;
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:    state_d = S_TRAP;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    // Every state that leads back to FETCH (other than an illegal skip) completes an instruction.
    assign retire     = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                        (state_q == S_ALUWB) || (state_q == S_BEQ);
    assign inst_ret_d = inst_ret_q + {{(CNT_W-1){1'b0}}, retire};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_FETCH;
            inst_ret_q <= '0;
        end else begin
            state_q    <= state_d;
            inst_ret_q <= inst_ret_d;
        end
    end

    always_comb begin
        ALUOP     = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        case (state_q)
            S_FETCH:    begin IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1; end
            S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
            S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
            S_EXECR:    begin ALUSrcA = 2'b10; ALUOP = 2'b10; end
            S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOP = 2'b10; end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ:      begin ALUSrcA = 2'b10; ALUOP = 2'b01; PCWrite = Zero; end
            S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
            default:    ;
        endcase
    end

    assign ImmSrc  = (opcode == OP_SW)  ? 2'b01 :
                     (opcode == OP_BEQ) ? 2'b10 :
                     (opcode == OP_JAL) ? 2'b11 : 2'b00;
`ifdef ILLEGAL_TRAP_EN
    assign Illegal = (state_q == S_TRAP);
`else
    assign Illegal = 1'b0;
`endif
    assign InstRet = inst_ret_q;
endmodule
